mux5_arbiter: RTL and testbench
===============================

// Module: mux5_arbiter
// PURPOSE
//  Upstream control stage for the 5-input byte mux (mux5_8). Arbitrates among five byte sources
//  and drives the mux select, so exactly one source's byte appears on the mux output at a time.
//  Moves bytes in bursts to a downstream consumer using a valid/ready handshake.
//  Returns a one-hot ack to the source whose byte was taken.
// PARAMETERS
//  MAX_BURST  4  max bytes per grant before forced re-arbitration; legal 1..2**CNT_W
//  CNT_W      3  burst counter width
// PORTS
//  Clk        in   1      system clock, rising edge
//  Reset_n    in   1      asynchronous, active-low reset
//  req        in   5      req[i]=1: source i has a byte on Din<i>; held until acked
//  last       in   5      last[i]=1: current byte of source i ends its packet
//  out_ready  in   1      downstream accepts the mux output this cycle
//  select     out  3      mux select, binary 0..4; values 5..7 never driven
//  out_valid  out  1      mux output (Dout) is valid
//  ack        out  5      one-hot; ack[select]=1 in the cycle a byte transfers
//  busy       out  1      1 while in GRANT
//  drop_err   out  1      1-cycle pulse: granted source dropped req mid-burst
// BEHAVIOUR
//  Reset values: select=0, out_valid=0, ack=0, busy=0, drop_err=0, rr_ptr=4, burst_cnt=0, state=IDLE.
//  Reset is async. Asserting it mid-burst clears all outputs immediately; the burst is abandoned.
//  FSM has two states, IDLE and GRANT.
//  IDLE, req==0: stay in IDLE; select holds its last value; out_valid=0.
//  IDLE, req!=0:
//   - Winner = first i with req[i]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo 5.
//   - Register select=winner, clear burst_cnt, go to GRANT.
//   - Latency: req rising -> out_valid=1 on the next clock edge (1 cycle).
//  GRANT:
//   - out_valid = req[select] (combinational); busy=1; select is stable for the whole grant.
//   - Transfer = out_valid & out_ready. ack[select]=transfer (combinational); burst_cnt++ on each transfer.
//   - Grant ends on the transfer where last[select]=1 or burst_cnt==MAX_BURST-1:
//     go to IDLE and set rr_ptr=select.
//   - If req[select]=0 while in GRANT: no transfer, drop_err pulses 1 cycle,
//     go to IDLE, set rr_ptr=select.
//   - out_ready=0: hold everything (select, burst_cnt); no ack.
//  There is one idle bubble cycle between grants, because re-arbitration always passes through IDLE.
//  last[] is sampled only for the granted source, and only on a transfer. All other req/last bits are ignored.
//  burst_cnt never wraps: the grant ends at MAX_BURST-1. With MAX_BURST=1, every grant is a single byte.
//  Requests arriving for other sources during GRANT are held off until IDLE.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN defined:
//   - Fixed priority, lowest index wins (source 0 highest).
//   - rr_ptr is neither used nor updated; starvation of high indices is allowed.
//  ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.
// TESTING
//  1 Reset_n=0 at any time -> select=0, out_valid=0, ack=0, busy=0, drop_err=0 in the same cycle.
//  2 req=00100, out_ready=1, last[2]=1 on the 2nd byte:
//    - select=2, out_valid=1 one cycle after req.
//    - ack=00100 for 2 cycles, then IDLE (busy=0).
//  3 req=10001 held, last=0, out_ready=1:
//    - Grants in order 0,4,0,4, 4 acks each, 1 bubble cycle between grants.
//    - With ARB_FIXED_PRIO_EN: always 0.
//  4 Grant to source 3, out_ready=0 for 3 cycles:
//    - out_valid=1, select=3, ack=0, burst_cnt unchanged.
//    - Transfer occurs on the first cycle out_ready=1.
//  5 Grant to source 1, req[1] dropped after 1 byte:
//    - drop_err=1 for 1 cycle, then IDLE.
//    - Next arbitration with req=00011 picks source 0 (rr_ptr=1 scans from 2, wraps to 0).
//  6 Reset_n pulsed low mid-burst on source 4:
//    - All outputs clear at once.
//    - After release with req=10000, source 4 is granted again; burst_cnt restarts at 0.

Source files
------------

// File: rtl/mux5_arbiter.sv
// ---------------------------------------------------------------------------
// mux5_arbiter
//   Control stage for the 5-input byte mux (mux5_8). Picks one of five byte
//   sources, drives the mux select for the whole grant, and moves that
//   source's bytes downstream in bursts over a valid/ready handshake. The
//   source whose byte was taken receives a one-hot ack in the transfer cycle.
//
//   Arbitration is round-robin by default. Define ARB_FIXED_PRIO_EN to get
//   fixed priority instead (source 0 highest, no rr pointer).
//
// Parameters
//   MAX_BURST  bytes per grant before forced re-arbitration (1..2**CNT_W)
//   CNT_W      burst counter width
//
// Ports
//   Clk        in   1  system clock, rising edge
//   Reset_n    in   1  asynchronous, active-low reset
//   req        in   5  source i has a byte on Din<i>; held until acked
//   last       in   5  current byte of source i ends its packet
//   out_ready  in   1  downstream accepts the mux output this cycle
//   select     out  3  mux select, binary 0..4
//   out_valid  out  1  mux output is valid
//   ack        out  5  one-hot ack to the source whose byte transferred
//   busy       out  1  high while a grant is active
//   drop_err   out  1  one-cycle pulse: granted source dropped req mid-burst
// ---------------------------------------------------------------------------
module mux5_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [4:0]       req,
    input  logic [4:0]       last,
    input  logic             out_ready,
    output logic [2:0]       select,
    output logic             out_valid,
    output logic [4:0]       ack,
    output logic             busy,
    output logic             drop_err
);

    // Count value on which the final byte of a full-length burst transfers.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       select_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             found;
    logic             req_sel;

    assign req_sel = req[select];

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            idx = 3'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    logic [2:0] rr_ptr;

    // Scan starts one past the last granted source and wraps modulo 5.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= 5; k++) begin
            idx = 3'((32'(rr_ptr) + k) % 5);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr <= 3'd4;
        end else if (state == GRANT && state_nxt == IDLE) begin
            rr_ptr <= select;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            select    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            select    <= select_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        select_nxt = select;
        cnt_nxt    = burst_cnt;
        busy       = 1'b0;
        out_valid  = 1'b0;
        ack        = '0;
        drop_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    select_nxt = winner;
                    cnt_nxt    = '0;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                out_valid = req_sel;
                if (!req_sel) begin
                    drop_err  = 1'b1;
                    state_nxt = IDLE;
                end else if (out_ready) begin
                    ack = 5'(1) << select;
                    if (last[select] || burst_cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = burst_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux5_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux5_arbiter
//   Scoreboard bench for mux5_arbiter. The driver applies stimulus shortly
//   after each rising edge and steps a behavioural model that pushes the
//   expected output record for every active cycle. A monitor on the falling
//   edge pops and compares whenever the DUT shows activity, and checks the
//   held select value in idle cycles.
// ---------------------------------------------------------------------------
module tb_mux5_arbiter;

    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [4:0] req = '0;
    logic [4:0] last = '0;
    logic       out_ready = 1'b0;
    logic [2:0] select;
    logic       out_valid;
    logic [4:0] ack;
    logic       busy;
    logic       drop_err;

    mux5_arbiter #(
        .MAX_BURST(MAX_BURST),
        .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .req(req),
        .last(last),
        .out_ready(out_ready),
        .select(select),
        .out_valid(out_valid),
        .ack(ack),
        .busy(busy),
        .drop_err(drop_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         cyc;
        int         sel;
        bit         valid;
        logic [4:0] ack;
        bit         drop;
    } rec_t;

    rec_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: which source holds the grant (-1 = none), bytes moved
    // in this grant, last granted source, and the select value seen when idle.
    int         cur = -1;
    int         nbytes = 0;
    int         rr = 4;
    int         last_sel = 0;
    int         exp_idle_sel = 0;
    logic [4:0] acked_prev = '0;

    always @(posedge Clk) cyc++;

    function automatic int pick(input logic [4:0] r);
`ifdef ARB_FIXED_PRIO_EN
        for (int unsigned i = 0; i < 5; i++)
            if (r[i]) return int'(i);
`else
        for (int unsigned k = 1; k <= 5; k++)
            if (r[(rr + int'(k)) % 5]) return (rr + int'(k)) % 5;
`endif
        return -1;
    endfunction

    task automatic model_step();
        rec_t r;
        bit   v;
        bit   tr;
        exp_idle_sel = last_sel;
        acked_prev   = '0;
        if (cur >= 0) begin
            v       = req[cur];
            tr      = v && out_ready;
            r.cyc   = cyc;
            r.sel   = cur;
            r.valid = v;
            r.ack   = tr ? 5'(1 << cur) : 5'b0;
            r.drop  = !v;
            sbq.push_back(r);
            acked_prev = r.ack;
            if (!v) begin
                rr  = cur;
                cur = -1;
            end else if (tr) begin
                nbytes++;
                if (last[cur] || nbytes == MAX_BURST) begin
                    rr  = cur;
                    cur = -1;
                end
            end
        end else if (req != 5'b0) begin
            cur      = pick(req);
            nbytes   = 0;
            last_sel = cur;
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] l,
                         input logic rdy, input int n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            req       = r;
            last      = l;
            out_ready = rdy;
            model_step();
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (select !== 3'd0 || out_valid !== 1'b0 || ack !== 5'b0 ||
            busy !== 1'b0 || drop_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: sel=%0d valid=%b ack=%b busy=%b drop=%b, required all zero",
                     name, select, out_valid, ack, busy, drop_err);
        end
    endtask

    // Assert reset away from the edge, check outputs clear at once, hold for
    // two edges, then release and let that cycle arbitrate normally.
    task automatic pulse_reset(input string name);
        @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs(name);
        cur = -1;
        nbytes = 0;
        rr = 4;
        last_sel = 0;
        acked_prev = '0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_step();
    endtask

    // Monitor
    always @(negedge Clk) begin : monitor
        rec_t r;
        if (Reset_n) begin
            checks++;
            if (busy || out_valid || ack != 5'b0 || drop_err) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d: sel=%0d valid=%b ack=%b drop=%b, required idle",
                             cyc, select, out_valid, ack, drop_err);
                end else begin
                    r = sbq.pop_front();
                    if (r.cyc != cyc || int'(select) != r.sel || out_valid != r.valid ||
                        ack != r.ack || drop_err != r.drop || busy != 1'b1) begin
                        errors++;
                        $display("FAIL grant_cycle cyc=%0d: sel=%0d valid=%b ack=%b drop=%b busy=%b, required cyc=%0d sel=%0d valid=%b ack=%b drop=%b busy=1",
                                 cyc, select, out_valid, ack, drop_err, busy,
                                 r.cyc, r.sel, r.valid, r.ack, r.drop);
                    end
                end
            end else begin
                if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                    r = sbq.pop_front();
                    errors++;
                    $display("FAIL missing_output cyc=%0d: DUT idle, required sel=%0d valid=%b ack=%b drop=%b",
                             cyc, r.sel, r.valid, r.ack, r.drop);
                end else if (int'(select) != exp_idle_sel) begin
                    errors++;
                    $display("FAIL idle_select cyc=%0d: sel=%0d, required %0d",
                             cyc, select, exp_idle_sel);
                end
            end
        end
    end

    initial begin
        logic [4:0] nr;
        #2;
        check_reset_outputs("reset_initial");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        model_step();

        // Single source, packet ends on its second byte.
        drive(5'b00100, 5'b00000, 1'b1, 2);
        drive(5'b00100, 5'b00100, 1'b1, 1);
        drive(5'b00000, 5'b00000, 1'b1, 3);

        // Two sources held, no last: alternating full bursts.
        drive(5'b10001, 5'b00000, 1'b1, 25);
        drive(5'b00000, 5'b00000, 1'b1, 2);

        // Back-pressure on source 3.
        drive(5'b01000, 5'b00000, 1'b0, 4);
        drive(5'b01000, 5'b00000, 1'b1, 1);
        drive(5'b01000, 5'b01000, 1'b1, 1);
        drive(5'b00000, 5'b00000, 1'b1, 2);

        // Source 1 drops req after one byte, then 0 and 1 both request.
        pulse_reset("reset_before_drop");
        drive(5'b00010, 5'b00000, 1'b1, 2);
        drive(5'b00000, 5'b00000, 1'b1, 1);
        drive(5'b00011, 5'b00000, 1'b1, 6);
        drive(5'b00000, 5'b00000, 1'b1, 2);

        // Reset mid-burst on source 4; burst must restart from zero.
        drive(5'b10000, 5'b00000, 1'b1, 3);
        pulse_reset("reset_mid_burst");
        drive(5'b10000, 5'b00000, 1'b1, 7);
        drive(5'b00000, 5'b00000, 1'b1, 2);

        // Randomized traffic from well-behaved sources with occasional drops.
        for (int unsigned n = 0; n < 3000; n++) begin
            if (n == 1000 || n == 2000) pulse_reset("reset_random");
            @(posedge Clk);
            #1;
            for (int unsigned i = 0; i < 5; i++) begin
                if (req[i]) begin
                    if (acked_prev[i]) nr[i] = ($urandom % 2) == 0;
                    else               nr[i] = ($urandom % 24) != 0;
                end else begin
                    nr[i] = ($urandom % 3) == 0;
                end
            end
            req       = nr;
            last      = 5'($urandom) & 5'($urandom);
            out_ready = ($urandom % 4) != 0;
            model_step();
        end

        @(negedge Clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d records left, required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
